fft_bfly_r2: RTL and testbench

- Radix-2 FFT butterfly stage, downstream of the twiddle/operand-select path and upstream of the stage memory write-back.
- Accepts one complex operand pair (A, B) per handshake and produces X = A+B and Y = A−B per component.
- Applies optional 1/2 scaling with rounding, or saturation when unscaled.
- Two-stage registered pipeline with valid/ready flow control and a sticky overflow flag.

---
 rtl/fft_pkg.sv | 17 +
 rtl/fft_bfly_scale.sv | 45 ++++
 rtl/fft_bfly_r2.sv | 124 ++++++++++++
 tb/tb_fft_bfly_r2.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the radix-2 FFT butterfly datapath.
package fft_pkg;

  // Default component width: signed two's complement, real and imaginary.
  parameter int FFT_W = 8;

  // Saturation bounds for an FFT_W-bit signed component.
  localparam logic signed [FFT_W-1:0] SAT_MAX = {1'b0, {(FFT_W-1){1'b1}}};
  localparam logic signed [FFT_W-1:0] SAT_MIN = {1'b1, {(FFT_W-1){1'b0}}};

  // One complex sample.
  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_bfly_scale.sv
// Output conditioning for one butterfly component. It takes a WIDTH+1-bit sum
// or difference and returns a WIDTH-bit result. With scaling on, the value is
// halved and rounded half toward +inf; this can never overflow. With scaling
// off, the value is clamped to the WIDTH-bit range and o_sat reports the clamp.
module fft_bfly_scale
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_W
) (
  input  logic signed [WIDTH:0]   i_s,
  input  logic                    i_scale,
  output logic signed [WIDTH-1:0] o_r,
  output logic                    o_sat
);

  localparam logic signed [WIDTH-1:0] LP_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] LP_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // (s + 1) at WIDTH+2 bits so the increment cannot wrap. Bits [WIDTH:1] are the
  // arithmetic shift right by one.
  logic [WIDTH+1:0] w_inc;
  logic             w_ovr;
  logic             w_unused_bits;

  assign w_inc = {i_s[WIDTH], i_s} + {{(WIDTH+1){1'b0}}, 1'b1};

  // The top bit and bit 0 of the increment carry no information for the result.
  assign w_unused_bits = w_inc[WIDTH+1] ^ w_inc[0];

  // The value leaves the WIDTH range when the two top bits disagree.
  assign w_ovr = i_s[WIDTH] ^ i_s[WIDTH-1];

  // Choose the rounded half, the clamped value or the pass-through value.
  always_comb begin
    o_r   = i_s[WIDTH-1:0];
    o_sat = 1'b0;
    if (i_scale) begin
      o_r = w_inc[WIDTH:1];
    end else if (w_ovr) begin
      o_sat = 1'b1;
      o_r   = i_s[WIDTH] ? LP_MIN : LP_MAX;
    end
  end

endmodule

// File: rtl/fft_bfly_r2.sv
// Radix-2 FFT butterfly: X = A + B, Y = A - B on complex operands.
// Two registered stages:
//   S1 holds the exact WIDTH+1-bit sums and differences.
//   S2 holds the scaled or saturated WIDTH-bit results.
// The sticky overflow flag records any saturated sample that is delivered.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its data stable until that edge. in_ready depends
// combinationally on out_ready (there is no skid buffer), and a stalled result
// on the outputs does not change until it transfers.
module fft_bfly_r2
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_scale,
  input  logic signed [WIDTH-1:0] a_re,
  input  logic signed [WIDTH-1:0] a_im,
  input  logic signed [WIDTH-1:0] b_re,
  input  logic signed [WIDTH-1:0] b_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_re,
  output logic signed [WIDTH-1:0] x_im,
  output logic signed [WIDTH-1:0] y_re,
  output logic signed [WIDTH-1:0] y_im,
  output logic                    ovf,
  output logic                    ovf_sticky,
  input  logic                    ovf_clr
);

  // Component order in the arrays below: 0 = x_re, 1 = x_im, 2 = y_re, 3 = y_im.
  logic                    r_s1_valid;
  logic                    r_s1_scale;
  logic signed [WIDTH:0]   r_s1_s [4];

  logic                    r_s2_valid;
  logic signed [WIDTH-1:0] r_s2_r [4];
  logic                    r_ovf;
  logic                    r_ovf_sticky;

  logic                    w_s2_load;
  logic                    w_s1_load;
  logic                    w_in_fire;
  logic                    w_out_fire;
  logic signed [WIDTH-1:0] w_r [4];
  logic [3:0]              w_sat;

  // S2 may load when it is empty or when its current result leaves this cycle.
  // S1 may load when it is empty or when its content moves into S2.
  assign w_out_fire = r_s2_valid && out_ready;
  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_s1_load  = !r_s1_valid || w_s2_load;
  assign w_in_fire  = in_valid && w_s1_load;
  assign in_ready   = w_s1_load;

  // Stage 1: sign-extend to WIDTH+1 bits so the sums and differences are exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_scale <= 1'b0;
      for (int i = 0; i < 4; i++) r_s1_s[i] <= '0;
    end else begin
      if (w_s1_load) r_s1_valid <= in_valid;
      if (w_in_fire) begin
        r_s1_scale <= in_scale;
        r_s1_s[0]  <= {a_re[WIDTH-1], a_re} + {b_re[WIDTH-1], b_re};
        r_s1_s[1]  <= {a_im[WIDTH-1], a_im} + {b_im[WIDTH-1], b_im};
        r_s1_s[2]  <= {a_re[WIDTH-1], a_re} - {b_re[WIDTH-1], b_re};
        r_s1_s[3]  <= {a_im[WIDTH-1], a_im} - {b_im[WIDTH-1], b_im};
      end
    end
  end

  // One conditioning slice per output component.
  for (genvar g = 0; g < 4; g++) begin : g_scale
    fft_bfly_scale #(.WIDTH(WIDTH)) u_scale (
      .i_s     (r_s1_s[g]),
      .i_scale (r_s1_scale),
      .o_r     (w_r[g]),
      .o_sat   (w_sat[g])
    );
  end

  // Stage 2: capture the conditioned results. They stay unchanged while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < 4; i++) r_s2_r[i] <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_ovf <= |w_sat;
        for (int i = 0; i < 4; i++) r_s2_r[i] <= w_r[i];
      end
    end
  end

  // Sticky overflow is set by a saturated sample when it transfers out.
  // A set in the same cycle as ovf_clr takes priority over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_out_fire && r_ovf) begin
      r_ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf_sticky <= 1'b0;
    end
  end

  assign out_valid  = r_s2_valid;
  assign x_re       = r_s2_r[0];
  assign x_im       = r_s2_r[1];
  assign y_re       = r_s2_r[2];
  assign y_im       = r_s2_r[3];
  assign ovf        = r_ovf;
  assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_fft_bfly_r2.sv
// Testbench for fft_bfly_r2. It runs a table of vectors, a back-to-back stream
// under a toggling out_ready, sticky-flag sequences and reset during traffic.
// Expected results go into a queue when an input transfers, and they are
// compared whenever out_valid is high.
module tb_fft_bfly_r2;
  import fft_pkg::*;

  localparam int W = FFT_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                in_valid  = 1'b0;
  logic                in_scale  = 1'b0;
  logic                out_ready = 1'b0;
  logic                ovf_clr   = 1'b0;
  logic signed [W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  wire                 in_ready, out_valid, ovf, ovf_sticky;
  wire signed [W-1:0]  x_re, x_im, y_re, y_im;

  fft_bfly_r2 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_scale(in_scale),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
    .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  // ---------------- scoreboard state ----------------
  int           n_cmp = 0;
  int           n_err = 0;
  logic [4*W:0] exp_q[$];        // {x_re, x_im, y_re, y_im, ovf}
  logic [4*W:0] drv_exp = '0;    // expected result of the operands being driven
  logic         mdl_sticky = 1'b0;
  logic         last_acc = 1'b0;

  typedef struct {
    logic sc;
    int   ar, ai, br, bi;
    int   xr, xi, yr, yi;
    logic ov;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference for one component: exact sum in, WIDTH-bit result out.
  function automatic logic [W:0] comp_model(input int s, input logic sc);
    int   r;
    int   t;
    logic f;
    f = 1'b0;
    t = s + 1;
    if (sc) r = (t >= 0) ? t / 2 : -((1 - t) / 2);
    else if (s > int'(SAT_MAX)) begin r = int'(SAT_MAX); f = 1'b1; end
    else if (s < int'(SAT_MIN)) begin r = int'(SAT_MIN); f = 1'b1; end
    else r = s;
    return {f, r[W-1:0]};
  endfunction

  function automatic logic [4*W:0] bfly_model(input logic sc, input int ar, input int ai,
                                              input int br, input int bi);
    logic [W:0] xr, xi, yr, yi;
    xr = comp_model(ar + br, sc);
    xi = comp_model(ai + bi, sc);
    yr = comp_model(ar - br, sc);
    yi = comp_model(ai - bi, sc);
    return {xr[W-1:0], xi[W-1:0], yr[W-1:0], yi[W-1:0], xr[W] | xi[W] | yr[W] | yi[W]};
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle. Call it just after a rising edge. It checks at the falling
  // edge, then updates the model at the rising edge.
  task automatic tick();
    logic acc, dlv;
    @(negedge clk);
    acc = in_valid && in_ready;
    dlv = out_valid && out_ready;
    chk("in_ready", in_ready, !(exp_q.size() == 2 && !out_ready));
    if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 1'b0);
      else chk("out_xy_ovf", {x_re, x_im, y_re, y_im, ovf}, exp_q[0]);
    end
    chk("ovf_sticky", ovf_sticky, mdl_sticky);
    @(posedge clk);
    if (dlv && exp_q.size() > 0) begin
      if (exp_q[0][0]) mdl_sticky = 1'b1;
      else if (ovf_clr) mdl_sticky = 1'b0;
      void'(exp_q.pop_front());
    end else if (ovf_clr) begin
      mdl_sticky = 1'b0;
    end
    if (acc) exp_q.push_back(drv_exp);
    last_acc = acc;
    #1;
  endtask

  task automatic apply_vec(input vec_t v);
    logic [W-1:0] t0, t1, t2, t3;
    in_scale = v.sc;
    a_re = v.ar[W-1:0]; a_im = v.ai[W-1:0];
    b_re = v.br[W-1:0]; b_im = v.bi[W-1:0];
    t0 = v.xr[W-1:0]; t1 = v.xi[W-1:0]; t2 = v.yr[W-1:0]; t3 = v.yi[W-1:0];
    drv_exp = {t0, t1, t2, t3, v.ov};
  endtask

  task automatic set_rand();
    in_scale = 1'($urandom_range(0, 1));
    a_re = W'($urandom_range(0, 255)); a_im = W'($urandom_range(0, 255));
    b_re = W'($urandom_range(0, 255)); b_im = W'($urandom_range(0, 255));
    drv_exp = bfly_model(in_scale, int'(a_re), int'(a_im), int'(b_re), int'(b_im));
  endtask

  task automatic send();
    int n;
    n = 0;
    in_valid = 1'b1;
    last_acc = 1'b0;
    while (!last_acc && n < 20) begin tick(); n++; end
    in_valid = 1'b0;
    chk("send_accepted", last_acc, 1'b1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_out_valid", out_valid, 1'b0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic pat[4];
    int   sent, cyc;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    vecs[0] = '{1'b0,   10,  -20,    5,    7,   15,  -13,    5,  -27, 1'b0};
    vecs[1] = '{1'b0,  100, -100,  100,  100,  127,    0,    0, -128, 1'b1};
    vecs[2] = '{1'b1, -128,    3, -128,   -2, -128,    1,    0,    3, 1'b0};
    vecs[3] = '{1'b0,  127,  127,  127, -128,  127,   -1,    0,  127, 1'b1};
    vecs[4] = '{1'b1,  127,   -1,  127,    0,  127,    0,    0,    0, 1'b0};
    vecs[5] = '{1'b0, -128, -128,    1,   -1, -127, -128, -128, -127, 1'b1};
    vecs[6] = '{1'b1,   -3,   -1,    0,    0,   -1,    0,   -1,    0, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_xy", {x_re, x_im, y_re, y_im}, '0);
    chk("reset_ovf", ovf, 1'b0);
    chk("reset_ovf_sticky", ovf_sticky, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", in_ready, 1'b1);

    // Latency: out_valid rises two edges after the input transfer
    out_ready = 1'b1;
    apply_vec(vecs[0]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_edge1_out_valid", out_valid, 1'b0);
    tick();
    chk("lat_edge2_out_valid", out_valid, 1'b1);
    drain();

    // Table vectors, one at a time
    for (int i = 0; i < 7; i++) begin
      apply_vec(vecs[i]);
      send();
      drain();
    end

    // The table contained saturating samples, so sticky is set; clear it
    chk("sticky_after_table", ovf_sticky, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("sticky_cleared", ovf_sticky, 1'b0);

    // Clear during an accepted saturated output: the set takes priority
    apply_vec(vecs[1]);
    ovf_clr = 1'b1;
    send();
    drain();
    ovf_clr = 1'b0;
    chk("sticky_set_beats_clr", ovf_sticky, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;

    // Saturated sample stalled for 3 cycles with a clear pulse, then accepted
    out_ready = 1'b0;
    apply_vec(vecs[3]);
    send();
    tick();
    chk("stall_out_valid", out_valid, 1'b1);
    for (int k = 0; k < 3; k++) begin
      ovf_clr = (k == 1);
      tick();
      chk("stall_sticky_clear", ovf_sticky, 1'b0);
    end
    ovf_clr   = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("stall_sticky_after_accept", ovf_sticky, 1'b1);
    drain();

    // 8 random samples back to back with out_ready cycling 1,0,0,1
    sent = 0;
    cyc  = 0;
    set_rand();
    while ((sent < 8 || exp_q.size() > 0) && cyc < 200) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      tick();
      if (last_acc) begin
        sent++;
        if (sent < 8) set_rand();
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("b2b_sent", sent, 8);
    chk("b2b_all_delivered", exp_q.size(), 0);

    // Reset with two samples in flight
    out_ready = 1'b0;
    set_rand();
    in_valid = 1'b1;
    tick();
    set_rand();
    tick();
    in_valid = 1'b0;
    chk("pre_reset_full_in_ready", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", out_valid, 1'b0);
    chk("async_reset_in_ready", in_ready, 1'b1);
    exp_q.delete();
    mdl_sticky = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("post_reset_no_stale", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
